// File: rtl/regfile_ctrl_pkg.sv
// Shared command opcodes and controller state encoding for the register-file
// access sequencer.
package regfile_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_DUMP  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR        = 3'd1,
        ST_RD        = 3'd2,
        ST_RESP      = 3'd3,
        ST_DUMP_RD   = 3'd4,
        ST_DUMP_RESP = 3'd5,
        ST_CLR       = 3'd6
    } state_e;

endpackage

// File: rtl/regfile_ctrl.sv
// Command sequencer on the master side of the dual-read register file:
// write / read / dump / clear commands in, read responses out.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | cmd_ready high, waiting for a command
// ST_WR        | single write cycle (suppressed for address 0)
// ST_RD        | read ports driven, data captured at end of second cycle
// ST_RESP      | read response held until rsp_ready
// ST_DUMP_RD   | read pair (idx, idx+1)
// ST_DUMP_RESP | dump pair response held until rsp_ready
// ST_CLR       | zeroing addresses 1..DEPTH-1, one per cycle
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [N-1:0] cmd_addr,
    input  logic [N-1:0] cmd_addr2,
    input  logic [W-1:0] cmd_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data1,
    output logic [W-1:0] rsp_data2,
    output logic [N-1:0] rsp_addr,
    output logic         rsp_last,
    output logic         busy,
    output logic         rf_we,
    output logic [N-1:0] rf_addr_rd,
    output logic [W-1:0] rf_data_in,
    output logic [N-1:0] rf_addr_rs1,
    output logic [N-1:0] rf_addr_rs2,
    input  logic [W-1:0] rf_rs1,
    input  logic [W-1:0] rf_rs2
);

    localparam int           DEPTH     = 1 << N;
    localparam logic [N-1:0] LAST_PAIR = N'(DEPTH - 2);
    localparam logic [N-1:0] LAST_ADDR = '1;

    state_e       state_q;
    logic         cmd_ready_q;
    logic         rd_phase_q;
    logic [N-1:0] idx_q;
    logic         rsp_valid_q;
    logic [W-1:0] rsp_data1_q;
    logic [W-1:0] rsp_data2_q;
    logic [N-1:0] rsp_addr_q;
    logic         rsp_last_q;
    logic         rf_we_q;
    logic [N-1:0] rf_addr_rd_q;
    logic [W-1:0] rf_data_in_q;
    logic [N-1:0] rf_addr_rs1_q;
    logic [N-1:0] rf_addr_rs2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            rd_phase_q    <= 1'b0;
            idx_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data1_q   <= '0;
            rsp_data2_q   <= '0;
            rsp_addr_q    <= '0;
            rsp_last_q    <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_addr_rd_q  <= '0;
            rf_data_in_q  <= '0;
            rf_addr_rs1_q <= '0;
            rf_addr_rs2_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        case (op_e'(cmd_op))
                            OP_WRITE: begin
                                state_q      <= ST_WR;
                                rf_we_q      <= (cmd_addr != '0);
                                rf_addr_rd_q <= cmd_addr;
                                rf_data_in_q <= cmd_data;
                            end
                            OP_READ: begin
                                state_q       <= ST_RD;
                                rd_phase_q    <= 1'b0;
                                rf_addr_rs1_q <= cmd_addr;
                                rf_addr_rs2_q <= cmd_addr2;
                            end
                            OP_DUMP: begin
                                state_q       <= ST_DUMP_RD;
                                rd_phase_q    <= 1'b0;
                                idx_q         <= '0;
                                rf_addr_rs1_q <= '0;
                                rf_addr_rs2_q <= N'(1);
                            end
                            OP_CLEAR: begin
                                state_q      <= ST_CLR;
                                rf_we_q      <= 1'b1;
                                rf_addr_rd_q <= N'(1);
                                rf_data_in_q <= '0;
                            end
                        endcase
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end

                ST_WR: begin
                    state_q      <= ST_IDLE;
                    cmd_ready_q  <= 1'b1;
                    rf_we_q      <= 1'b0;
                    rf_addr_rd_q <= '0;
                    rf_data_in_q <= '0;
                end

                // Read ports are held for two cycles so rsp_valid rises two
                // edges after the command is accepted.
                ST_RD, ST_DUMP_RD: begin
                    if (!rd_phase_q) begin
                        rd_phase_q <= 1'b1;
                    end else begin
                        rd_phase_q    <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_data1_q   <= rf_rs1;
                        rsp_data2_q   <= rf_rs2;
                        rsp_addr_q    <= rf_addr_rs1_q;
                        rsp_last_q    <= (state_q == ST_RD) || (idx_q == LAST_PAIR);
                        rf_addr_rs1_q <= '0;
                        rf_addr_rs2_q <= '0;
                        state_q       <= (state_q == ST_RD) ? ST_RESP : ST_DUMP_RESP;
                    end
                end

                ST_RESP, ST_DUMP_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (rsp_last_q) begin
                            state_q     <= ST_IDLE;
                            cmd_ready_q <= 1'b1;
                        end else begin
                            state_q       <= ST_DUMP_RD;
                            idx_q         <= idx_q + N'(2);
                            rf_addr_rs1_q <= idx_q + N'(2);
                            rf_addr_rs2_q <= idx_q + N'(3);
                        end
                    end
                end

                ST_CLR: begin
                    if (rf_addr_rd_q == LAST_ADDR) begin
                        state_q      <= ST_IDLE;
                        cmd_ready_q  <= 1'b1;
                        rf_we_q      <= 1'b0;
                        rf_addr_rd_q <= '0;
                    end else begin
                        rf_addr_rd_q <= rf_addr_rd_q + N'(1);
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b0;
                    rf_we_q     <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = (state_q != ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data1   = rsp_data1_q;
    assign rsp_data2   = rsp_data2_q;
    assign rsp_addr    = rsp_addr_q;
    assign rsp_last    = rsp_last_q;
    assign rf_we       = rf_we_q;
    assign rf_addr_rd  = rf_addr_rd_q;
    assign rf_data_in  = rf_data_in_q;
    assign rf_addr_rs1 = rf_addr_rs1_q;
    assign rf_addr_rs2 = rf_addr_rs2_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Scoreboard bench for regfile_ctrl: a behavioural register bank plus a
// reference model that predicts responses and write traffic per command.
module tb_regfile_ctrl;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 1 << N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = '0;
    logic [N-1:0] cmd_addr = '0;
    logic [N-1:0] cmd_addr2 = '0;
    logic [W-1:0] cmd_data = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data1, rsp_data2;
    logic [N-1:0] rsp_addr;
    logic         rsp_last;
    logic         busy;
    logic         rf_we;
    logic [N-1:0] rf_addr_rd, rf_addr_rs1, rf_addr_rs2;
    logic [W-1:0] rf_data_in, rf_rs1, rf_rs2;

    regfile_ctrl #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_addr2(cmd_addr2), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
        .rsp_addr(rsp_addr), .rsp_last(rsp_last), .busy(busy),
        .rf_we(rf_we), .rf_addr_rd(rf_addr_rd), .rf_data_in(rf_data_in),
        .rf_addr_rs1(rf_addr_rs1), .rf_addr_rs2(rf_addr_rs2),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2)
    );

    always #5 clk = ~clk;

    // Register bank environment: register 0 reads as zero, reads combinational.
    logic [W-1:0] rf_mem [DEPTH] = '{default: '0};
    always @(posedge clk) if (rf_we && rf_addr_rd != '0) rf_mem[rf_addr_rd] <= rf_data_in;
    assign rf_rs1 = rf_mem[rf_addr_rs1];
    assign rf_rs2 = rf_mem[rf_addr_rs2];

    typedef struct { logic [W-1:0] d1; logic [W-1:0] d2; logic [N-1:0] a; logic last; } rsp_t;
    typedef struct { logic [N-1:0] a; logic [W-1:0] d; } wr_t;

    rsp_t         exp_q [$];
    wr_t          wq [$];
    logic [W-1:0] ref_mem [DEPTH];
    int checks = 0;
    int errors = 0;
    int resp_count = 0;
    int we_count = 0;
    int bp_mode = 0;   // 0 always ready, 1 random, 2 held low

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ($urandom_range(0, 2) != 0);
            default: rsp_ready = 1'b0;
        endcase
    end

    // Monitor: compare presented response against queue head every cycle it is
    // valid, pop on handshake; check every write against the write queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_we) begin
                we_count++;
                if (wq.size() == 0) begin
                    chk("unexpected_write", {rf_addr_rd, rf_data_in}, '1);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("write_addr", rf_addr_rd, w.a);
                    chk("write_data", rf_data_in, w.d);
                end
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", rsp_addr, '1);
                end else begin
                    rsp_t e;
                    e = exp_q[0];
                    chk("rsp_data1", rsp_data1, e.d1);
                    chk("rsp_data2", rsp_data2, e.d2);
                    chk("rsp_addr", rsp_addr, e.a);
                    chk("rsp_last", rsp_last, e.last);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        resp_count++;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] a2, input logic [W-1:0] d);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_timeout", cmd_ready, 1'b1);
        if (!cmd_ready) return;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_addr2 = a2; cmd_data = d;
        case (op)
            2'b00: if (a != '0) begin
                ref_mem[a] = d;
                wq.push_back('{a: a, d: d});
            end
            2'b01: exp_q.push_back('{d1: ref_mem[a], d2: ref_mem[a2], a: a, last: 1'b1});
            2'b10: for (int i = 0; i < DEPTH; i += 2)
                exp_q.push_back('{d1: ref_mem[i], d2: ref_mem[i+1], a: N'(i), last: (i == DEPTH-2)});
            default: for (int i = 1; i < DEPTH; i++) begin
                ref_mem[i] = '0;
                wq.push_back('{a: N'(i), d: '0});
            end
        endcase
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || wq.size() != 0 || busy) && n < 600) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_timeout", (exp_q.size() == 0 && wq.size() == 0 && !busy), 1'b1);
    endtask

    function automatic logic [63:0] all_outs();
        return {cmd_ready, rsp_valid, rsp_data1, rsp_data2, rsp_addr, rsp_last, busy,
                rf_we, rf_addr_rd, rf_data_in, rf_addr_rs1, rf_addr_rs2};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", all_outs(), '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_reset", cmd_ready, 1'b1);
        chk("busy_after_reset", busy, 1'b0);

        // 1: write then read with latency check
        bp_mode = 0;
        issue(2'b00, 4'd3, 4'd0, 8'hA5);
        drain();
        issue(2'b01, 4'd3, 4'd0, 8'h00);
        chk("busy_in_read", busy, 1'b1);
        chk("ready_drop", cmd_ready, 1'b0);
        @(posedge clk); #1 chk("rsp_valid_t1", rsp_valid, 1'b0);
        @(posedge clk); #1 chk("rsp_valid_t2", rsp_valid, 1'b1);
        drain();

        // 2: write to address 0 is suppressed
        base = we_count;
        issue(2'b00, 4'd0, 4'd0, 8'hFF);
        drain();
        chk("addr0_no_write", we_count - base, 0);
        issue(2'b01, 4'd0, 4'd0, 8'h00);
        drain();

        // 3: response held under backpressure
        bp_mode = 2;
        issue(2'b01, 4'd3, 4'd3, 8'h00);
        repeat (2) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_ready_low", cmd_ready, 1'b0);
        end
        bp_mode = 0;
        n = 0;
        while (rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("hold_release_valid", rsp_valid, 1'b0);
        chk("ready_after_rsp", cmd_ready, 1'b1);
        drain();

        // random mix with random backpressure
        bp_mode = 1;
        for (int k = 0; k < 40; k++) begin
            int r;
            r = $urandom_range(0, 9);
            issue((r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11,
                  N'($urandom), N'($urandom), W'($urandom));
        end
        drain();

        // 4: pattern fill then dump
        for (int k = 1; k < DEPTH; k++) issue(2'b00, N'(k), 4'd0, W'(k * 8'h11));
        issue(2'b10, 4'd0, 4'd0, 8'h00);
        drain();

        // 5: clear then dump
        base = we_count;
        issue(2'b11, 4'd0, 4'd0, 8'h00);
        drain();
        chk("clear_write_cycles", we_count - base, DEPTH - 1);
        issue(2'b10, 4'd0, 4'd0, 8'h00);
        drain();

        // 6: asynchronous reset in the middle of a dump
        base = resp_count;
        issue(2'b10, 4'd0, 4'd0, 8'h00);
        n = 0;
        while (resp_count - base < 3 && n < 300) begin @(negedge clk); n++; end
        chk("dump_progress", resp_count - base >= 3, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_reset_outputs", all_outs(), '0);
        exp_q.delete();
        wq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_rerelease", cmd_ready, 1'b1);
        issue(2'b01, 4'd5, 4'd6, 8'h00);
        drain();

        chk("exp_queue_empty", exp_q.size(), 0);
        chk("write_queue_empty", wq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
